dmem_copy_engine: RTL
=====================

// Module: dmem_copy_engine
// PURPOSE
//   Bus initiator for the 256x8 data memory: moves a block of bytes (copy) or stores a constant (fill)
//   without core involvement. Drives the memory's write-enable/address/write-data port; consumes its
//   combinational read data. Sits beside the core; core muxes memory port to engine while busy=1.
// PARAMETERS
//   ADDR_W  8  memory address width; pointers wrap modulo 2**ADDR_W
//   DATA_W  8  memory word width
// PORTS
//   clk           in   1       rising-edge clock
//   rst_n         in   1       asynchronous, active-low reset
//   start         in   1       request; sampled only in IDLE
//   mode          in   1       0 = copy src->dst, 1 = fill dst with fillValue
//   srcAddr       in   ADDR_W  first source address (copy only)
//   dstAddr       in   ADDR_W  first destination address
//   length        in   ADDR_W  byte count, 0..255; 0 = no-op
//   fillValue     in   DATA_W  fill byte (fill only)
//   abort         in   1       cancel in-flight transfer
//   busy          out  1       high in READ/WRITE
//   done          out  1       one-cycle completion pulse
//   memWen        out  1       memory write enable
//   memAddress    out  ADDR_W  memory address
//   memWriteData  out  DATA_W  memory write data
//   memReadData   in   DATA_W  memory read data, combinational from memAddress, same cycle
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE, all pointers/counters/data regs 0; busy=done=memWen=0,
//     memAddress=memWriteData=0, effective immediately without a clock edge.
//   - Outputs decoded from state/regs only (no input->output combinational paths except none).
//   - FSM: IDLE, READ, WRITE, DONE.
//   - IDLE: outputs all 0. On start=1: latch srcAddr,dstAddr,length,mode,fillValue.
//     length==0 -> DONE; mode=0 -> READ; mode=1 -> WRITE.
//   - READ: memAddress=srcPtr, memWen=0; at edge dataReg<=memReadData, -> WRITE.
//   - WRITE: memAddress=dstPtr, memWen=1, memWriteData = mode ? fillReg : dataReg. At edge:
//     srcPtr++, dstPtr++ (wrap 0xFF->0x00), remaining--; remaining==1 -> DONE, else copy->READ, fill->WRITE.
//   - DONE: done=1, busy=0, memWen=0 for exactly one cycle; -> IDLE.
//   - Latency from start edge: copy N bytes = 2N cycles in READ/WRITE then done; fill = N cycles then done;
//     length 0 = done in the cycle after the start edge.
//   - start while not IDLE (incl. DONE cycle): ignored, no re-latch.
//   - abort sampled at edge in READ/WRITE: write of a current WRITE cycle still happens; next state IDLE,
//     no done pulse. abort in IDLE/DONE ignored. abort and start together in IDLE: start wins.
//   - Overlapping regions: strictly ascending byte-by-byte; dst inside (src, src+len) replicates the
//     leading bytes. Defined behaviour, not corrected.
// STRUCTURE
//   - Shared package dmem_pkg: ADDR_W/DATA_W constants, copy_state_t enum {IDLE,READ,WRITE,DONE},
//     MODE_COPY=1'b0 / MODE_FILL=1'b1.
//   - Single module; no sub-module warranted (pointers and counter inline).
//   - Bench pairs the engine with the existing DataMemory model on the same clk.
// TESTING
//   1. rst_n=0 with no clock -> busy=0, done=0, memWen=0, memAddress=0x00, memWriteData=0x00.
//   2. Copy src=0x10 dst=0x40 len=3, mem[0x10..0x12]=AA,BB,CC -> mem[0x40..0x42]=AA,BB,CC; memWen high
//      3 non-consecutive cycles; done pulses 6 cycles after start edge, busy low again.
//   3. Fill dst=0xFE len=4 fillValue=0x5A -> writes at FE,FF,00,01 on 4 consecutive cycles; done next cycle.
//   4. len=0 (either mode) -> no memWen, done one cycle after start; start repeated during busy ignored.
//   5. Copy len=5, abort asserted in 2nd WRITE cycle -> exactly 2 bytes written, no done, IDLE next.
//   6. rst_n dropped mid-WRITE -> memWen falls immediately; after release, new copy runs correctly.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory copy/fill engine.
package dmem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } copy_state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/dmem_copy_engine_if.sv
// Port bundle between the copy engine (master) and the 256x8 data memory (slave).
interface dmem_copy_engine_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  // No valid/ready on this bus: memWen=1 commits memWriteData to memAddress at the next
  // rising clk edge, and memReadData follows memAddress combinationally in the same cycle.
  logic              memWen;
  logic [ADDR_W-1:0] memAddress;
  logic [DATA_W-1:0] memWriteData;
  logic [DATA_W-1:0] memReadData;

  modport master (
    output memWen,
    output memAddress,
    output memWriteData,
    input  memReadData
  );

  modport slave (
    input  memWen,
    input  memAddress,
    input  memWriteData,
    output memReadData
  );

endinterface

// File: rtl/dmem_copy_engine.sv
// Memory-port initiator that copies a byte block (READ/WRITE pairs) or fills it with a constant.
// All outputs are registers loaded from the next-state decode, so nothing is combinational from inputs.
module dmem_copy_engine
  import dmem_pkg::*;
#(
  parameter int ADDR_W = dmem_pkg::ADDR_W,
  parameter int DATA_W = dmem_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   srcAddr,
  input  logic [ADDR_W-1:0]   dstAddr,
  input  logic [ADDR_W-1:0]   length,
  input  logic [DATA_W-1:0]   fillValue,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output copy_state_t         dbg_state_o,
  dmem_copy_engine_if.master  mem
);

  copy_state_t       state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    data_d  = data_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d  = srcAddr;
          dst_d  = dstAddr;
          rem_d  = length;
          mode_d = mode;
          fill_d = fillValue;
          if (length == '0)           state_d = DONE;
          else if (mode == MODE_FILL) state_d = WRITE;
          else                        state_d = READ;
        end
      end
      READ: begin
        data_d  = mem.memReadData;
        state_d = abort ? IDLE : WRITE;
      end
      WRITE: begin
        // The write of this cycle is committed by the memory regardless of abort.
        src_d = src_q + ADDR_W'(1);
        dst_d = dst_q + ADDR_W'(1);
        rem_d = rem_q - ADDR_W'(1);
        if (abort)                      state_d = IDLE;
        else if (rem_q == ADDR_W'(1))   state_d = DONE;
        else if (mode_q == MODE_FILL)   state_d = WRITE;
        else                            state_d = READ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Output registers are decoded from the state being entered.
    busy_d  = 1'b0;
    done_d  = 1'b0;
    wen_d   = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    unique case (state_d)
      READ: begin
        busy_d = 1'b1;
        addr_d = src_d;
      end
      WRITE: begin
        busy_d  = 1'b1;
        wen_d   = 1'b1;
        addr_d  = dst_d;
        wdata_d = (mode_d == MODE_FILL) ? fill_d : data_d;
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      mode_q  <= MODE_COPY;
      fill_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign dbg_state_o      = state_q;
  assign mem.memWen       = wen_q;
  assign mem.memAddress   = addr_q;
  assign mem.memWriteData = wdata_q;

endmodule
